hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand bypass selection, load-use and branch
// handling, and data-memory wait/timeout supervision with a stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemAccessM,
    input  logic        DMemReadyM,
    input  logic        FaultClr,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemFault,
    output logic [31:0] StallCount
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] MWAIT = 2'd1;
    localparam logic [1:0] ERR   = 2'd2;

    // MEM_TIMEOUT is expected to be at least 1; the width guard keeps 0/1 legal.
    localparam int unsigned      CNT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_wcnt;
    logic [31:0]      r_stall_cnt;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_wcnt_nxt;
    logic [CNT_W-1:0] w_wcnt_inc;
    logic             w_in_mwait;
    logic             w_in_err;
    logic             w_in_run;
    logic             w_lw_stall;
    logic             w_mem_wait;
    logic             w_hold;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       we_m,
        input logic [4:0] rd_m,
        input logic       we_w,
        input logic [4:0] rd_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

    assign w_in_mwait = (r_state == MWAIT);
    assign w_in_err   = (r_state == ERR);
    // Any undefined encoding decodes as RUN so the outputs stay well-formed.
    assign w_in_run   = !w_in_mwait && !w_in_err;

    assign w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_mem_wait = (w_in_run && MemAccessM && !DMemReadyM) ||
                        (w_in_mwait && !DMemReadyM);
    assign w_hold     = w_mem_wait || w_in_err;

    // A frozen pipeline must not also be bubbled, so flushes yield to w_hold.
    assign StallF   = !rst && (w_hold || w_lw_stall);
    assign StallD   = !rst && (w_hold || w_lw_stall);
    assign StallE   = !rst && w_hold;
    assign StallM   = !rst && w_hold;
    assign FlushD   = !rst && !w_hold && PCSrcE;
    assign FlushE   = !rst && !w_hold && (w_lw_stall || PCSrcE);
    assign FlushW   = !rst && w_hold;
    assign MemFault = w_in_err;

    assign StallCount = r_stall_cnt;
    assign w_wcnt_inc = r_wcnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            MWAIT: begin
                // Ready wins over a coincident timeout.
                if (DMemReadyM) begin
                    w_state_nxt = RUN;
                end else begin
                    w_wcnt_nxt = w_wcnt_inc;
                    if (w_wcnt_inc == TIMEOUT_C)
                        w_state_nxt = ERR;
                end
            end
            ERR: begin
                if (FaultClr)
                    w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
                if (MemAccessM && !DMemReadyM) begin
                    w_state_nxt = MWAIT;
                    w_wcnt_nxt  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_wcnt      <= '0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (StallF)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush,
// memory wait, timeout/fault clear, and asynchronous reset recovery.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemAccessM, DMemReadyM, FaultClr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        MemFault;
    logic [31:0] StallCount;

    logic [3:0]  st;
    logic [2:0]  fl;
    int          checks   = 0;
    int          failures = 0;

    assign st = {StallF, StallD, StallE, StallM};
    assign fl = {FlushD, FlushE, FlushW};

    hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
        .DMemReadyM(DMemReadyM), .FaultClr(FaultClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemFault(MemFault), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; MemAccessM = 1'b0;
        DMemReadyM = 1'b1; FaultClr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        MemAccessM = 1'b1; DMemReadyM = 1'b0;
        repeat (3) step();
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL reset_stalls got=%b exp=0000", st); end
        checks++; if (fl !== 3'b000) begin failures++; $display("FAIL reset_flushes got=%b exp=000", fl); end
        checks++; if (MemFault !== 1'b0) begin failures++; $display("FAIL reset_memfault got=%b exp=0", MemFault); end
        checks++; if (StallCount !== 32'd0) begin failures++; $display("FAIL reset_stallcount got=%0d exp=0", StallCount); end
        clear_inputs();
        #2;
        rst = 1'b0;
        step();
        checks++; if (StallCount !== 32'd0) begin failures++; $display("FAIL post_reset_stallcount got=%0d exp=0", StallCount); end
    endtask

    task automatic test_forward();
        clear_inputs();
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
        #1;
        checks++; if (ForwardAE !== 2'b10) begin failures++; $display("FAIL fwdA_mem got=%b exp=10", ForwardAE); end
        RdM = 5'd0;
        #1;
        checks++; if (ForwardAE !== 2'b01) begin failures++; $display("FAIL fwdA_wb got=%b exp=01", ForwardAE); end
        RdW = 5'd0;
        #1;
        checks++; if (ForwardAE !== 2'b00) begin failures++; $display("FAIL fwdA_none got=%b exp=00", ForwardAE); end
        RdM = 5'd3; Rs2E = 5'd3; RdW = 5'd3; RegWriteM = 1'b0;
        #1;
        checks++; if (ForwardBE !== 2'b01) begin failures++; $display("FAIL fwdB_wb_when_m_off got=%b exp=01", ForwardBE); end
        RegWriteM = 1'b1;
        #1;
        checks++; if (ForwardBE !== 2'b10) begin failures++; $display("FAIL fwdB_mem got=%b exp=10", ForwardBE); end
        checks++; if (ForwardAE !== 2'b00) begin failures++; $display("FAIL fwdA_unrelated got=%b exp=00", ForwardAE); end
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        checks++; if (StallCount !== 32'd0) begin failures++; $display("FAIL lu_count_before got=%0d exp=0", StallCount); end
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 7'd7;
        #1;
        checks++; if (st !== 4'b1100) begin failures++; $display("FAIL lu_stalls got=%b exp=1100", st); end
        checks++; if (fl !== 3'b010) begin failures++; $display("FAIL lu_flushes got=%b exp=010", fl); end
        step();
        clear_inputs();
        #1;
        checks++; if (StallCount !== 32'd1) begin failures++; $display("FAIL lu_count_after got=%0d exp=1", StallCount); end
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL lu_released got=%b exp=0000", st); end
        ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0; Rs1D = 5'd0;
        #1;
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL lu_rd0_stalls got=%b exp=0000", st); end
        checks++; if (fl !== 3'b000) begin failures++; $display("FAIL lu_rd0_flushes got=%b exp=000", fl); end
        step();
        checks++; if (StallCount !== 32'd1) begin failures++; $display("FAIL lu_rd0_count got=%0d exp=1", StallCount); end
        clear_inputs();
    endtask

    task automatic test_branch();
        clear_inputs();
        PCSrcE = 1'b1;
        #1;
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL br_stalls got=%b exp=0000", st); end
        checks++; if (fl !== 3'b110) begin failures++; $display("FAIL br_flushes got=%b exp=110", fl); end
        MemAccessM = 1'b1; DMemReadyM = 1'b0;
        #1;
        checks++; if (st !== 4'b1111) begin failures++; $display("FAIL br_memw_stalls got=%b exp=1111", st); end
        checks++; if (fl !== 3'b001) begin failures++; $display("FAIL br_memw_flushes got=%b exp=001", fl); end
        DMemReadyM = 1'b1;
        #1;
        checks++; if (fl !== 3'b110) begin failures++; $display("FAIL br_ready_flushes got=%b exp=110", fl); end
        step();
        clear_inputs();
        #1;
        checks++; if (StallCount !== 32'd1) begin failures++; $display("FAIL br_count got=%0d exp=1", StallCount); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemAccessM = 1'b1; DMemReadyM = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (st !== 4'b1111) begin failures++; $display("FAIL mw_stalls cyc=%0d got=%b exp=1111", c, st); end
            checks++; if (fl !== 3'b001) begin failures++; $display("FAIL mw_flushes cyc=%0d got=%b exp=001", c, fl); end
            step();
        end
        DMemReadyM = 1'b1; PCSrcE = 1'b1;
        #1;
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL mw_ready_stalls got=%b exp=0000", st); end
        checks++; if (fl !== 3'b110) begin failures++; $display("FAIL mw_ready_flushes got=%b exp=110", fl); end
        step();
        clear_inputs();
        DMemReadyM = 1'b0;
        #1;
        checks++; if (StallCount !== 32'd3) begin failures++; $display("FAIL mw_count got=%0d exp=3", StallCount); end
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL mw_back_in_run got=%b exp=0000", st); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        MemAccessM = 1'b1; DMemReadyM = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (c == 8) FaultClr = 1'b1;
            if (c == 9) FaultClr = 1'b0;
            checks++; if (st !== 4'b1111 || MemFault !== 1'b0) begin failures++; $display("FAIL to_wait cyc=%0d got=%b/%b exp=1111/0", c, st, MemFault); end
            step();
        end
        #1;
        checks++; if (MemFault !== 1'b1) begin failures++; $display("FAIL to_fault got=%b exp=1", MemFault); end
        checks++; if (st !== 4'b1111) begin failures++; $display("FAIL to_err_stalls got=%b exp=1111", st); end
        checks++; if (fl !== 3'b001) begin failures++; $display("FAIL to_err_flushes got=%b exp=001", fl); end
        checks++; if (StallCount !== 32'd16) begin failures++; $display("FAIL to_count got=%0d exp=16", StallCount); end
        MemAccessM = 1'b0; DMemReadyM = 1'b1;
        step();
        checks++; if (MemFault !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", MemFault); end
        FaultClr = 1'b1;
        step();
        FaultClr = 1'b0;
        #1;
        checks++; if (MemFault !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", MemFault); end
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL to_clear_stalls got=%b exp=0000", st); end
        checks++; if (StallCount !== 32'd18) begin failures++; $display("FAIL to_clear_count got=%0d exp=18", StallCount); end
        do_reset();
        MemAccessM = 1'b1; DMemReadyM = 1'b0;
        repeat (15) step();
        DMemReadyM = 1'b1;
        #1;
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL tie_stalls got=%b exp=0000", st); end
        step();
        MemAccessM = 1'b0; DMemReadyM = 1'b0;
        #1;
        checks++; if (MemFault !== 1'b0 || st !== 4'b0000) begin failures++; $display("FAIL tie_run got=%b/%b exp=0/0000", MemFault, st); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        MemAccessM = 1'b1; DMemReadyM = 1'b0;
        repeat (16) step();
        #2;
        checks++; if (MemFault !== 1'b1) begin failures++; $display("FAIL ar_in_err got=%b exp=1", MemFault); end
        rst = 1'b1;
        #1;
        checks++; if (MemFault !== 1'b0) begin failures++; $display("FAIL ar_memfault got=%b exp=0", MemFault); end
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL ar_stalls got=%b exp=0000", st); end
        checks++; if (StallCount !== 32'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", StallCount); end
        MemAccessM = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL ar_run_after got=%b exp=0000", st); end
        step();
        MemAccessM = 1'b1;
        step();
        MemAccessM = 1'b0;
        #1;
        checks++; if (st !== 4'b1111) begin failures++; $display("FAIL ar_mwait_entry got=%b exp=1111", st); end
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checks++; if (st !== 4'b0000) begin failures++; $display("FAIL ar_mwait_reset got=%b exp=0000", st); end
        step();
        checks++; if (st !== 4'b0000 || StallCount !== 32'd0) begin failures++; $display("FAIL ar_first_edge got=%b/%0d exp=0000/0", st, StallCount); end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
